// File: rtl/cardinal_nic_pkg.sv
// cardinal_nic_pkg: register map and status bit positions shared by the NIC and its users
package cardinal_nic_pkg;
  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;
  localparam int STAT_FULL_BIT = 63;
  localparam int STAT_OVF_BIT  = 62;
endpackage

// File: rtl/cardinal_nic_if.sv
// cardinal_nic_if: processor register port plus router ready/send port of the NIC
interface cardinal_nic_if #(parameter int DATA_WIDTH = 64, parameter int ADDR_WIDTH = 2);
  logic [ADDR_WIDTH-1:0] addr;
  logic [0:DATA_WIDTH-1] d_in, d_out, net_di, net_do;
  logic nicEn, nicWrEn, net_si, net_ri, net_so, net_ro;
  modport slave (input addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, output d_out, net_ri, net_so, net_do);
  modport master (output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, input d_out, net_ri, net_so, net_do);
endinterface

// File: rtl/nic_chan_buf.sv
// nic_chan_buf: single-entry packet buffer with load/clear and a full flag
module nic_chan_buf #(parameter int DATA_WIDTH = 64) (
  input  logic Clock,
  input  logic Reset,
  input  logic load,
  input  logic clear,
  input  logic [0:DATA_WIDTH-1] d,
  output logic [0:DATA_WIDTH-1] q,
  output logic full
);
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      q <= '0;
      full <= 1'b0;
    end else begin
      if (load) q <= d;
      full <= load | (full & ~clear);
    end
endmodule

// File: rtl/cardinal_nic.sv
// cardinal_nic: memory-mapped NIC bridging the processor data port and one ring-router node
module cardinal_nic import cardinal_nic_pkg::*; #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input logic Clock,
  input logic Reset,
  cardinal_nic_if.slave bus
);
  logic [ADDR_WIDTH-1:0] addr;
  logic rd, wr, out_wr, in_full, out_full, out_ovf;
  logic [0:DATA_WIDTH-1] in_buf, out_buf, in_stat, out_stat, rd_data, d_out;
  assign addr = bus.addr;
  assign rd = bus.nicEn & ~bus.nicWrEn;
  assign wr = bus.nicEn & bus.nicWrEn;
  assign out_wr = wr && addr == NIC_OUT_BUF;
  assign bus.net_ri = ~in_full;
  assign bus.net_so = out_full & bus.net_ro;
  assign bus.net_do = out_buf;
  assign bus.d_out = d_out;
  nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_in (
    .Clock(Clock), .Reset(Reset),
    .load(bus.net_si & ~in_full), .clear(rd && addr == NIC_IN_BUF),
    .d(bus.net_di), .q(in_buf), .full(in_full)
  );
  // acceptance uses pre-edge out_full, so a write racing a drain is still an overflow
  nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .Clock(Clock), .Reset(Reset),
    .load(out_wr & ~out_full), .clear(bus.net_so),
    .d(bus.d_in), .q(out_buf), .full(out_full)
  );
  always_comb begin
    in_stat = '0;
    in_stat[STAT_FULL_BIT] = in_full;
    out_stat = '0;
    out_stat[STAT_FULL_BIT] = out_full;
    out_stat[STAT_OVF_BIT] = out_ovf;
    rd_data = addr == NIC_IN_BUF ? in_buf : addr == NIC_IN_STAT ? in_stat : addr == NIC_OUT_STAT ? out_stat : '0;
  end
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      d_out <= '0;
      out_ovf <= 1'b0;
    end else begin
      if (rd) d_out <= rd_data;
      if (out_wr && out_full) out_ovf <= 1'b1;
      else if (rd && addr == NIC_OUT_STAT) out_ovf <= 1'b0;
    end
endmodule

// File: tb/tb_cardinal_nic.sv
// tb_cardinal_nic: directed scoreboard bench for the NIC register and router ports
module tb_cardinal_nic;
  import cardinal_nic_pkg::*;
  typedef struct { logic [0:63] v; logic [0:63] m; } exp_t;
  localparam logic [0:63] ALL = '1;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;
  cardinal_nic_if #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) bus();
  cardinal_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));
  exp_t rd_q[$];
  logic [0:63] eg_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int eg_cnt = 0;
  bit rd_pend = 0;
  bit proc_done = 0;
  task automatic check(string name, logic [0:63] act, logic [0:63] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic rd(logic [1:0] a, logic [0:63] v, logic [0:63] m);
    bus.addr = a;
    bus.nicWrEn = 1'b0;
    bus.nicEn = 1'b1;
    rd_q.push_back('{v, m});
    @(negedge Clock);
    bus.nicEn = 1'b0;
  endtask
  task automatic wr(logic [1:0] a, logic [0:63] d);
    bus.addr = a;
    bus.d_in = d;
    bus.nicWrEn = 1'b1;
    bus.nicEn = 1'b1;
    @(negedge Clock);
    bus.nicEn = 1'b0;
    bus.nicWrEn = 1'b0;
  endtask
  task automatic send(logic [0:63] d);
    int w = 0;
    bus.net_di = d;
    bus.net_si = 1'b1;
    #1;
    while (!bus.net_ri && w < 200) begin
      @(negedge Clock);
      #1;
      w++;
    end
    if (w >= 200) check("send_timeout", 64'(w), 64'd0);
    @(negedge Clock);
  endtask
  // monitor: read data one cycle after the read, egress whenever net_so will fire
  always @(negedge Clock) begin
    exp_t e;
    logic [0:63] x;
    #1;
    if (rd_pend) begin
      if (rd_q.size() == 0) check("rd_unexpected", bus.d_out, ALL);
      else begin
        e = rd_q.pop_front();
        if (e.m != 0) check("rd_data", bus.d_out & e.m, e.v & e.m);
      end
    end
    rd_pend = Reset && bus.nicEn && !bus.nicWrEn;
    if (Reset && bus.net_so) begin
      eg_cnt++;
      if (eg_q.size() == 0) check("egress_unexpected", bus.net_do, ALL);
      else begin
        x = eg_q.pop_front();
        check("egress", bus.net_do, x);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.addr = '0; bus.d_in = '0; bus.nicEn = 0; bus.nicWrEn = 0;
    bus.net_si = 0; bus.net_di = '0; bus.net_ro = 0;
    #1;
    check("rst_d_out", bus.d_out, 0);
    check("rst_net_ri", bus.net_ri, 1);
    check("rst_net_so", bus.net_so, 0);
    @(negedge Clock); @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    bus.net_si = 1; bus.net_di = 64'hDEADBEEF_00000001;
    @(negedge Clock);
    bus.net_si = 0;
    check("in_ri_low", bus.net_ri, 0);
    rd(NIC_IN_STAT, 64'h1, ALL);
    rd(NIC_IN_BUF, 64'hDEADBEEF_00000001, ALL);
    check("in_ri_back", bus.net_ri, 1);
    rd(NIC_IN_STAT, 64'h0, ALL);
    eg_q.push_back(64'hA5A5_0000_0000_1234);
    wr(NIC_OUT_BUF, 64'hA5A5_0000_0000_1234);
    check("eg_so_low", bus.net_so, 0);
    check("eg_do", bus.net_do, 64'hA5A5_0000_0000_1234);
    rd(NIC_OUT_STAT, 64'h1, ALL);
    bus.net_ro = 1;
    #1;
    check("eg_so_high", bus.net_so, 1);
    @(negedge Clock);
    check("eg_so_once", bus.net_so, 0);
    bus.net_ro = 0;
    rd(NIC_OUT_STAT, 64'h0, ALL);
    eg_q.push_back(64'h1);
    wr(NIC_OUT_BUF, 64'h1);
    wr(NIC_OUT_BUF, 64'h2);
    check("ovf_do_kept", bus.net_do, 64'h1);
    rd(NIC_OUT_STAT, 64'h3, ALL);
    rd(NIC_OUT_STAT, 64'h1, ALL);
    bus.net_ro = 1;
    @(negedge Clock);
    bus.net_ro = 0;
    bus.net_si = 1; bus.net_di = 64'h77;
    @(negedge Clock);
    bus.net_si = 0;
    wr(NIC_OUT_BUF, 64'h55);
    #2;
    bus.net_ro = 1;
    Reset = 1'b0;
    #1;
    check("mid_rst_d_out", bus.d_out, 0);
    check("mid_rst_ri", bus.net_ri, 1);
    check("mid_rst_so", bus.net_so, 0);
    check("mid_rst_do", bus.net_do, 0);
    @(negedge Clock);
    Reset = 1'b1;
    bus.net_ro = 0;
    rd(NIC_IN_STAT, 64'h0, ALL);
    rd(NIC_OUT_STAT, 64'h0, ALL);
    fork
      begin
        send(64'h11);
        send(64'h22);
        bus.net_si = 0;
      end
      begin
        @(negedge Clock); @(negedge Clock);
        rd(NIC_IN_BUF, 64'h11, ALL);
        @(negedge Clock); @(negedge Clock);
        rd(NIC_IN_BUF, 64'h22, ALL);
        rd(NIC_IN_STAT, 64'h0, ALL);
      end
    join
    fork
      begin
        for (int i = 0; i < 16; i++) send(64'h100 + 64'(i));
        bus.net_si = 0;
      end
      begin
        int nin = 0;
        int nout = 0;
        int it = 0;
        while ((nin < 16 || nout < 16) && it < 2000) begin
          it++;
          rd(NIC_IN_STAT, 64'h0, 64'h0);
          if (bus.d_out[STAT_FULL_BIT]) begin
            rd(NIC_IN_BUF, 64'h100 + 64'(nin), ALL);
            nin++;
          end
          rd(NIC_OUT_STAT, 64'h0, 64'h2);
          if (!bus.d_out[STAT_FULL_BIT] && nout < 16) begin
            eg_q.push_back(64'h200 + 64'(nout));
            wr(NIC_OUT_BUF, 64'h200 + 64'(nout));
            nout++;
          end
        end
        check("conc_in_count", 64'(nin), 64'd16);
        check("conc_out_count", 64'(nout), 64'd16);
        proc_done = 1;
      end
      begin
        int c = 0;
        while (!(proc_done && eg_q.size() == 0) && c < 5000) begin
          bus.net_ro = (c % 3 != 0);
          @(negedge Clock);
          c++;
        end
        bus.net_ro = 0;
      end
    join
    rd(NIC_OUT_STAT, 64'h0, ALL);
    @(negedge Clock); @(negedge Clock);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("eg_q_drained", 64'(eg_q.size()), 64'd0);
    check("eg_total", 64'(eg_cnt), 64'd18);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
